// File: rtl/subtractor_pkg.sv
// Shared definitions for the chunked subtractor: FSM state encoding and
// helpers that derive/validate the slice count from WIDTH and CHUNK.
package subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic bit width_ok(input int width, input int chunk);
    return (chunk > 32'sd0) && (width > 32'sd0) && ((width % chunk) == 32'sd0);
  endfunction

endpackage

// File: rtl/subtract_slice.sv
// Combinational CHUNK-bit ripple of full-subtractor bits. Also exposes the
// borrow entering the slice MSB so the caller can derive signed overflow.
module subtract_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             borrow_in,
  output logic [CHUNK-1:0] difference,
  output logic             borrow_out,
  output logic             borrow_msb
);

  logic [CHUNK:0] chain_s;

  // Bit-serial borrow ripple through the slice
  always_comb begin
    chain_s    = '0;
    difference = '0;
    chain_s[0] = borrow_in;
    for (int i = 0; i < CHUNK; i++) begin
      difference[i] = a[i] ^ b[i] ^ chain_s[i];
      chain_s[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain_s[i]);
    end
  end

  assign borrow_out = chain_s[CHUNK];
  assign borrow_msb = chain_s[CHUNK-1];

endmodule

// File: rtl/chunked_subtractor.sv
// Sequential a - b - borrow_in over WIDTH bits, one CHUNK-bit slice per clock,
// LSB slice first. Signed overflow output enabled by CHUNKED_SUBTRACTOR_OVERFLOW_EN.
module chunked_subtractor
  import subtractor_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] difference,
  output logic             borrow,
  output logic             overflow
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (!width_ok(WIDTH, CHUNK)) begin : g_param_check
    $error("chunked_subtractor: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             bcur_r;
  logic [IDX_W-1:0] idx_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;
  logic             out_valid_r;

  logic [CHUNK-1:0] slice_diff_s;
  logic             slice_bout_s;
  logic             slice_bmsb_s;

  // Operands are shifted down each BUSY cycle, so the active slice is always the low CHUNK bits
  subtract_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a          (a_r[CHUNK-1:0]),
    .b          (b_r[CHUNK-1:0]),
    .borrow_in  (bcur_r),
    .difference (slice_diff_s),
    .borrow_out (slice_bout_s),
    .borrow_msb (slice_bmsb_s)
  );

`ifdef CHUNKED_SUBTRACTOR_OVERFLOW_EN
  logic overflow_r;
  assign overflow = overflow_r;
`else
  logic unused_slice_bmsb;
  assign unused_slice_bmsb = slice_bmsb_s;
  assign overflow          = 1'b0;
`endif

  // Control FSM with operand capture, per-slice result write and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      bcur_r      <= 1'b0;
      idx_r       <= '0;
      diff_r      <= '0;
      borrow_r    <= 1'b0;
      out_valid_r <= 1'b0;
`ifdef CHUNKED_SUBTRACTOR_OVERFLOW_EN
      overflow_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            bcur_r  <= borrow_in;
            idx_r   <= '0;
            state_r <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          diff_r[int'(idx_r)*CHUNK +: CHUNK] <= slice_diff_s;
          bcur_r <= slice_bout_s;
          a_r    <= a_r >> CHUNK;
          b_r    <= b_r >> CHUNK;
          if (idx_r == LAST_IDX) begin
            idx_r       <= '0;
            borrow_r    <= slice_bout_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
`ifdef CHUNKED_SUBTRACTOR_OVERFLOW_EN
            overflow_r  <= slice_bmsb_s ^ slice_bout_s;
`endif
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = (state_r == IDLE);
  assign out_valid  = out_valid_r;
  assign difference = diff_r;
  assign borrow     = borrow_r;

endmodule

// File: tb/tb_chunked_subtractor.sv
// Self-checking bench for chunked_subtractor: directed vector table, handshake
// corner sequences and randomized operations against an arithmetic reference.
module tb_chunked_subtractor;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;
`ifdef CHUNKED_SUBTRACTOR_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             borrow_in = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] difference;
  logic             borrow;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  chunked_subtractor #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .difference (difference),
    .borrow     (borrow),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Plain-arithmetic reference: unsigned borrow and signed range overflow
  task automatic ref_sub(input logic [31:0] ra, input logic [31:0] rb, input logic rbin,
                         output logic [31:0] rd, output logic rbo, output logic rov);
    longint ua, ub, sa, sb, sr;
    ua  = longint'(ra);
    ub  = longint'(rb);
    sa  = longint'($signed(ra));
    sb  = longint'($signed(rb));
    rd  = ra - rb - {31'd0, rbin};
    rbo = (ua < ub + longint'(rbin));
    sr  = sa - sb - longint'(rbin);
    rov = OVF_EN && ((sr > 64'sd2147483647) || (sr < -64'sd2147483648));
  endtask

  // Present operands at a negedge; accepted at the following posedge
  task automatic drive(input logic [31:0] da, input logic [31:0] db, input logic dbin);
    check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    a = da;
    b = db;
    borrow_in = dbin;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_valid(input string name);
    int lat;
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(NCHUNK));
  endtask

  task automatic collect(input string name, input logic [31:0] ed, input logic eb,
                         input logic eo, input int stall);
    wait_valid(name);
    check({name, "_in_ready_done"}, {63'd0, in_ready}, 64'd0);
    repeat (stall) @(negedge clk);
    check({name, "_out_valid"}, {63'd0, out_valid}, 64'd1);
    check({name, "_difference"}, {32'd0, difference}, {32'd0, ed});
    check({name, "_borrow"}, {63'd0, borrow}, {63'd0, eb});
    check({name, "_overflow"}, {63'd0, overflow}, {63'd0, eo});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_out_valid_after"}, {63'd0, out_valid}, 64'd0);
    check({name, "_in_ready_after"}, {63'd0, in_ready}, 64'd1);
  endtask

  vec_t vecs[7];

  initial begin
    logic [31:0] rd;
    logic        rbo, rov;

    vecs[0] = '{"small",     32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
    vecs[1] = '{"ripple",    32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[2] = '{"interslc",  32'h0000_0100, 32'h0000_0001, 1'b1, 32'h0000_00FE, 1'b0, 1'b0};
    vecs[3] = '{"minneg",    32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, OVF_EN};
    vecs[4] = '{"allones",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[5] = '{"maxpos",    32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, OVF_EN};
    vecs[6] = '{"zero_bin",  32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_difference", {32'd0, difference}, 64'd0);
    check("reset_borrow", {63'd0, borrow}, 64'd0);
    check("reset_overflow", {63'd0, overflow}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].bin);
      collect(vecs[i].name, vecs[i].diff, vecs[i].bout, vecs[i].ovf, 0);
    end

    // Stall in DONE with new operands waiting; they must only be taken after IDLE
    drive(32'h0000_0010, 32'h0000_0003, 1'b0);
    wait_valid("stall");
    a = 32'h0000_0020;
    b = 32'h0000_0001;
    borrow_in = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_difference", {32'd0, difference}, 64'h0000_000D);
      check("stall_out_valid", {63'd0, out_valid}, 64'd1);
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_release_out_valid", {63'd0, out_valid}, 64'd0);
    check("stall_release_in_ready", {63'd0, in_ready}, 64'd1);
    drive(32'h0000_0020, 32'h0000_0001, 1'b0);
    collect("stall_next", 32'h0000_001F, 1'b0, 1'b0, 0);

    // Reset in the middle of BUSY discards the operation
    drive(32'h1234_5678, 32'h0000_0001, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    check("midreset_difference", {32'd0, difference}, 64'd0);
    check("midreset_borrow", {63'd0, borrow}, 64'd0);
    check("midreset_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(32'd9, 32'd4, 1'b0);
    collect("after_reset", 32'd5, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      logic        rbin;
      ra   = $urandom;
      rb   = $urandom;
      rbin = 1'($urandom_range(1, 0));
      if (i % 8 == 3) rb = ra;
      if (i % 8 == 5) ra = 32'h8000_0000 ^ {31'd0, rbin};
      ref_sub(ra, rb, rbin, rd, rbo, rov);
      drive(ra, rb, rbin);
      collect("random", rd, rbo, rov, $urandom_range(3, 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
